bin2bcd_converter: RTL and testbench
====================================

Name: bin2bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the divider and the other ALU16 result paths.
- Takes a quotient, remainder or ALU result plus its error flag and produces packed BCD digits, a sign flag and an error flag for the seven-segment display driver.
- Uses iterative double-dabble (shift-add-3), one bit per clock, with a start/done handshake that matches the divider's.

Parameters:
- N, 16, width of the binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy DIGITS*4 >= bits needed for 2^N-1 in decimal. With N=16, 5 digits cover 0..65535.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion. Sampled only when idle.
- bin_in  input  N  binary value, captured on the accepting edge.
- is_signed  input  1  1 = treat bin_in as two's complement. Captured with bin_in.
- err_in  input  1  upstream error, e.g. divider div_by_zero. Captured with bin_in.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]. Holds until the next completion.
- neg  output  1  result is negative. Valid with bcd_out.
- err  output  1  conversion carried an upstream error. Valid with bcd_out.
- busy  output  1  conversion in progress. Start is ignored while high.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): bcd_out=0, neg=0, err=0, busy=0, done=0, state=IDLE, shift counter=0, scratch registers=0. Reset asserted mid-conversion aborts it with no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - done <= 0 unless set on this edge.
  - start=1 and err_in=1 (edge 0): bcd_out<=0, neg<=0, err<=1, done<=1, state stays IDLE. Latency is 1 edge.
  - start=1 and err_in=0 (edge 0): capture the magnitude. If is_signed=1 and bin_in[N-1]=1, magnitude = two's-complement negation in N bits, taken as unsigned, so 0x8000 gives 32768. Otherwise magnitude = bin_in.
  - On that edge also latch the sign, clear the BCD scratch, counter<=0, busy<=1, state<=SHIFT.
- SHIFT, each edge:
  - Every 4-bit scratch digit >=5 gets +3 (all digits in parallel, combinational).
  - Then shift the {scratch, magnitude} concatenation left by 1 and increment the counter.
  - After the N-th shift (edge N): bcd_out<=final scratch, neg<=latched sign, err<=0, done<=1, busy<=0, state<=IDLE.
- Latency: start accepted at edge 0, done high after edge N (16 cycles at the default), done low after edge N+1.
- Handshake:
  - start is ignored while busy=1.
  - A new start may be accepted on the edge where done drops (back-to-back operation).
  - start held high continuously triggers repeated conversions.
- -0 cannot occur. A magnitude of 0 always yields neg=0.
- bcd_out, neg and err change only on the completion edge and stay stable otherwise.

Test Plan:
- Unsigned: bin_in=16'd65535, is_signed=0, err_in=0, pulse start -> done exactly 16 cycles later, bcd_out=20'h65535, neg=0, err=0, busy high for cycles 1..16.
- Signed: bin_in=16'hFFFF, is_signed=1 -> bcd_out=20'h00001, neg=1. Then bin_in=16'h8000, is_signed=1 -> bcd_out=20'h32768, neg=1. Then bin_in=16'h0000 -> bcd_out=0, neg=0.
- Error path: err_in=1, bin_in=16'd1234, start -> done on the next edge, err=1, bcd_out=0, neg=0, busy never asserted.
- Start while busy: start at cycle 0 with 16'd42, pulse start again at cycle 5 with 16'd999 -> single done at cycle 16 with bcd_out=20'h00042. A start on the cycle after done converts 999 correctly.
- Reset mid-operation: start with 16'd500, assert rst_n=0 at cycle 8 -> all outputs 0 immediately, no done pulse. After release, a start with 16'd7 gives bcd_out=20'h00007.
- Divider chaining: divider computes 200/7, quotient fed on divider done -> bcd_out=20'h00028. Remainder path gives 20'h00004.

Source files
------------

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/done handshake bundle between a result producer and
// the binary-to-BCD converter.
//   master : drives start, bin_in, is_signed, err_in; observes the results
//   slave  : the converter; drives bcd_out, neg, err, busy, done
//   start      request a conversion (honoured only while idle)
//   bin_in     N-bit binary value
//   is_signed  bin_in is two's complement
//   err_in     upstream error (e.g. divide by zero)
//   bcd_out    packed BCD, digit 0 in bits [3:0]
//   neg        result is negative
//   err        result carries the upstream error
//   busy       conversion in progress
//   done       one-cycle completion pulse
interface bin2bcd_if #(
  parameter int N      = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [N-1:0]          bin_in;
  logic                  is_signed;
  logic                  err_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  logic                  err;
  logic                  busy;
  logic                  done;

  modport master (
    output start, bin_in, is_signed, err_in,
    input  bcd_out, neg, err, busy, done
  );

  modport slave (
    input  start, bin_in, is_signed, err_in,
    output bcd_out, neg, err, busy, done
  );
endinterface

// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: sequential double-dabble (shift-add-3) binary to BCD
// converter, one bit per clock, sitting downstream of the divider / ALU16.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bin2bcd_if slave modport (start/bin_in/is_signed/err_in in,
//          bcd_out/neg/err/busy/done out)
// A start with err_in set completes on the accepting edge with err=1 and a
// zero result; otherwise the magnitude is shifted through the BCD scratch
// over N edges and done pulses after the N-th shift.
module bin2bcd_converter #(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input logic      clk,
  input logic      rst_n,
  bin2bcd_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  scratch_q, scratch_d, scratch_adj;
  logic [N-1:0]  mag_q, mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic accept;
  logic reject;
  logic finish;

  assign accept = (state_q == IDLE)  && bus.start && !bus.err_in;
  assign reject = (state_q == IDLE)  && bus.start &&  bus.err_in;
  assign finish = (state_q == SHIFT) && (cnt_q == LAST_SHIFT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction applied to every digit in parallel before each shift
  always_comb begin
    scratch_adj = scratch_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Datapath next values
  always_comb begin
    scratch_d = scratch_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (accept) begin
      // Negative signed input: N-bit negation read as unsigned, so the most
      // negative value maps to 2^(N-1) rather than overflowing.
      sign_d    = bus.is_signed && bus.bin_in[N-1];
      mag_d     = sign_d ? (~bus.bin_in + N'(1)) : bus.bin_in;
      scratch_d = '0;
      cnt_d     = '0;
    end else if (reject) begin
      bcd_d  = '0;
      neg_d  = 1'b0;
      err_d  = 1'b1;
      done_d = 1'b1;
    end else if (state_q == SHIFT) begin
      {scratch_d, mag_d} = {scratch_adj[W-2:0], mag_q, 1'b0};
      cnt_d              = cnt_q + CW'(1);
      if (finish) begin
        bcd_d  = scratch_d;
        neg_d  = sign_q;
        err_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy    = (state_q == SHIFT);
    bus.done    = done_q;
    bus.bcd_out = bcd_q;
    bus.neg     = neg_q;
    bus.err     = err_q;
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: transaction-level reference
// model (decimal arithmetic plus a completion countdown), checked against
// the DUT every cycle, plus directed cases with literal expectations.
module tb_bin2bcd_converter;

  localparam int N      = 16;
  localparam int DIGITS = 5;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bin2bcd_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bin2bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic         m_busy, m_done, m_neg, m_err, m_pend_neg;
  logic [W-1:0] m_bcd, m_pend_bcd;
  int           m_left;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned magnitude(input logic [N-1:0] b, input logic s);
    if (s && b[N-1]) return (32'd1 << N) - 32'(b);
    return 32'(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_neg = 1'b0; m_err = 1'b0;
    m_bcd = '0; m_pend_bcd = '0; m_pend_neg = 1'b0; m_left = 0;
  endtask

  // One clock edge of the transaction model, using the inputs the bench drove
  task automatic model_edge();
    int unsigned mag;
    m_done = 1'b0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_bcd = m_pend_bcd; m_neg = m_pend_neg; m_err = 1'b0;
      end
    end else if (bus.start) begin
      if (bus.err_in) begin
        m_bcd = '0; m_neg = 1'b0; m_err = 1'b1; m_done = 1'b1;
      end else begin
        mag        = magnitude(bus.bin_in, bus.is_signed);
        m_pend_bcd = to_bcd(mag);
        m_pend_neg = (mag != 0) && bus.is_signed && bus.bin_in[N-1];
        m_left     = N;
        m_busy     = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
    check("neg",     32'(bus.neg),     32'(m_neg));
    check("err",     32'(bus.err),     32'(m_err));
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("done",    32'(bus.done),    32'(m_done));
  endtask

  // Drive inputs at the falling edge, model the rising edge, compare at the next falling edge
  task automatic step(input logic s, input logic [N-1:0] b, input logic sg, input logic e);
    bus.start = s; bus.bin_in = b; bus.is_signed = sg; bus.err_in = e;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      step(1'b0, '0, 1'b0, 1'b0);
      n++;
    end while (!bus.done && n < limit);
    check("done_within_bound", 32'(bus.done), 32'd1);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic convert(input logic [N-1:0] b, input logic sg, output int n);
    step(1'b1, b, sg, 1'b0);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(N + 4, n);
  endtask

  initial begin
    int n;
    int q, r;
    logic s, sg, e;

    bus.start = 1'b0; bus.bin_in = '0; bus.is_signed = 1'b0; bus.err_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_bcd",  32'(bus.bcd_out), 32'h0);
    check("rst_busy", 32'(bus.busy),    32'h0);
    check("rst_done", 32'(bus.done),    32'h0);
    check("rst_err",  32'(bus.err),     32'h0);
    rst_n = 1'b1;

    // Pin the model to hand-computed values
    check("model_65535", 32'(to_bcd(65535)), 32'h65535);
    check("model_neg1",  magnitude(16'hFFFF, 1'b1), 32'd1);
    check("model_8000",  32'(to_bcd(magnitude(16'h8000, 1'b1))), 32'h32768);
    check("model_unsig", magnitude(16'h8000, 1'b0), 32'd32768);

    // Unsigned full scale
    convert(16'd65535, 1'b0, n);
    check("lat_65535", 32'(n), 32'd16);
    check("bcd_65535", 32'(bus.bcd_out), 32'h65535);
    check("neg_65535", 32'(bus.neg), 32'd0);

    // Signed cases
    convert(16'hFFFF, 1'b1, n);
    check("bcd_m1", 32'(bus.bcd_out), 32'h00001);
    check("neg_m1", 32'(bus.neg), 32'd1);
    convert(16'h8000, 1'b1, n);
    check("bcd_min", 32'(bus.bcd_out), 32'h32768);
    check("neg_min", 32'(bus.neg), 32'd1);
    convert(16'h0000, 1'b1, n);
    check("bcd_zero", 32'(bus.bcd_out), 32'h0);
    check("neg_zero", 32'(bus.neg), 32'd0);

    // Error path: completes on the accepting edge
    step(1'b1, 16'd1234, 1'b0, 1'b1);
    check("err_done", 32'(bus.done), 32'd1);
    check("err_flag", 32'(bus.err), 32'd1);
    check("err_bcd",  32'(bus.bcd_out), 32'h0);
    check("err_busy", 32'(bus.busy), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Start while busy is ignored; back-to-back start on the done-drop edge
    step(1'b1, 16'd42, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 16'd999, 1'b0, 1'b0);
    wait_done(N + 4, n);
    check("busy_start_lat", 32'(n + 5), 32'd16);
    check("busy_start_bcd", 32'(bus.bcd_out), 32'h00042);
    convert(16'd999, 1'b0, n);
    check("b2b_lat", 32'(n), 32'd16);
    check("b2b_bcd", 32'(bus.bcd_out), 32'h00999);

    // Reset mid-conversion
    step(1'b1, 16'd500, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b0, '0, 1'b0, 1'b0);
    reset_now();
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    convert(16'd7, 1'b0, n);
    check("post_rst_bcd", 32'(bus.bcd_out), 32'h00007);

    // Divider chaining: 200 / 7
    q = 200 / 7;
    r = 200 % 7;
    convert(16'(q), 1'b0, n);
    check("div_quot", 32'(bus.bcd_out), 32'h00028);
    convert(16'(r), 1'b0, n);
    check("div_rem", 32'(bus.bcd_out), 32'h00004);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      sg = 1'($urandom);
      e  = ($urandom_range(0, 7) == 0);
      step(s, 16'($urandom), sg, e);
    end

    // start held high: repeated conversions
    for (int i = 0; i < 80; i++) step(1'b1, 16'($urandom), 1'($urandom), 1'b0);

    // Random mid-stream reset followed by more traffic
    reset_now();
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 2) == 0);
      step(s, 16'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
